burst_req_ctrl: RTL
===================

# burst_req_ctrl

Two-client burst requester that sits directly upstream of the two-way request/grant arbiter. It drives `req_0`/`req_1` and consumes `gnt_0`/`gnt_1`. It accepts one burst command per client, holds that client's request until its grant arrives, and streams the burst's beats onto a shared downstream bus. After the last beat it releases the request and waits for the grant to drop before accepting that client's next command.

## Interface
Parameters:
- `DATA_W`, 8: beat data width.
- `LEN_W`, 4: burst length field width; lengths 1..2^LEN_W-1.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid_0` / `cmd_valid_1`  in  1  client n offers a burst command.
- `cmd_len_0` / `cmd_len_1`  in  LEN_W  beats in burst; 0 is treated as 1.
- `cmd_ready_0` / `cmd_ready_1`  out  1  client n FSM is IDLE; command accepted on valid&&ready.
- `src_data_0` / `src_data_1`  in  DATA_W  client n's current beat data.
- `src_pop_0` / `src_pop_1`  out  1  one-cycle pulse when client n's beat is taken.
- `req_0` / `req_1`  out  1  registered request to the arbiter.
- `gnt_0` / `gnt_1`  in  1  grant from the arbiter.
- `bus_valid`  out  1  beat present.
- `bus_ready`  in  1  downstream accepts beat.
- `bus_data`  out  DATA_W  beat data; 0 when `bus_valid`=0.
- `bus_src`  out  1  owning client (0/1); 0 when idle.
- `bus_last`  out  1  final beat of burst.
- `err_dual_gnt`  out  1  sticky: both grants were seen high in the same cycle.

## Operation
- Each client has an independent FSM: IDLE -> REQ -> XFER -> RELEASE -> IDLE.
- IDLE: `cmd_ready_n`=1. When valid&&ready, load the remaining-beat counter with max(len,1) and go to REQ.
- REQ: `req_n`=1. Go to XFER when `gnt_n`=1.
- XFER: `req_n`=1. `bus_valid`=1 only while `gnt_n`=1.
  - A beat transfers when `bus_valid`&&`bus_ready`. On transfer, pulse `src_pop_n` and decrement the counter.
  - `bus_last`=1 when the counter equals 1.
  - After the beat with counter==1 transfers, go to RELEASE.
  - If `gnt_n` drops mid-burst, stall with `req_n` held high. No beats transfer and the counter is unchanged.
- RELEASE: `req_n`=0. Go to IDLE when `gnt_n`=0. A stale grant is never used for data.
- Bus mux is combinational from the owning XFER state and its grant.
- If both `gnt_0` and `gnt_1` are high in one cycle:
  - set `err_dual_gnt` (stays set until reset);
  - client 0 owns the bus; client 1 stalls that cycle.
- `req_n` is registered and equals (next state is REQ or XFER).
- Reset value of every output is 0, except `cmd_ready_0`/`cmd_ready_1`, which are 1. Counters reset to 0. Reset mid-burst aborts the burst; no further pops occur.

## Timing
- Arbiter behaviour this block is built against:
  - IDLE: `req_0` has priority.
  - A grant holds while its request stays high.
  - Grant outputs lag the arbiter state by one cycle.
- Command accepted in cycle t. `req_n` is high from t+1, and the arbiter enters its grant state at t+2.
- `gnt_n` rises at t+3. First `bus_valid` is at t+3 (combinational on the grant).
- With `bus_ready`=1, a burst of L beats occupies t+3..t+2+L. `req_n` falls at t+3+L.
- `gnt_n` is still high at t+3+L and t+4+L, with no `bus_valid` in those cycles. `gnt_n` is low at t+5+L.
- The FSM returns to IDLE at t+6+L, so `cmd_ready_n`=1 at t+6+L.
- Simultaneous commands: both requests rise together and the arbiter grants 0 first. Client 1 waits in REQ and is granted once `req_0` drops.

## Test plan
- Client 0, len=4, `bus_ready`=1, accepted at cycle 10:
  - `req_0` high cycles 11–16;
  - `bus_valid` cycles 13–16 with data = successive `src_data_0`;
  - `bus_last` at 16;
  - `cmd_ready_0` back at 20.
- Both clients command at cycle 10, len 2 each:
  - client 0 beats at 13–14;
  - `req_1` held high throughout;
  - client 1 beats once `gnt_1` rises, never overlapping;
  - `bus_src` = 0 then 1.
- Back-pressure: len=3, `bus_ready` low on alternate cycles:
  - exactly 3 `src_pop_0` pulses;
  - `bus_last` only on the third accepted beat;
  - data stable while stalled.
- len=0 on client 1 -> exactly one beat, with `bus_last`=1 on it.
- Reset asserted during the 2nd beat of a 4-beat burst:
  - next cycle all outputs at reset values and `cmd_ready_*`=1;
  - no further pops.
- Force `gnt_0`=`gnt_1`=1 for one cycle while both clients are in XFER:
  - `err_dual_gnt` is set and remains 1;
  - only client 0's beat transfers that cycle.

Source files
------------

// File: rtl/burst_req_ctrl.sv
// ---------------------------------------------------------------------------
// burst_req_ctrl
//
// Two-client burst requester sitting directly in front of a two-way
// request/grant arbiter. Each client hands over one burst command at a time.
// The block raises that client's request, waits for the grant, streams the
// client's beats onto one shared downstream bus, then drops the request and
// waits for the grant to go away before taking the client's next command.
//
// Parameters
//   DATA_W  beat data width
//   LEN_W   burst length field width (lengths 1..2^LEN_W-1, 0 counts as 1)
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   cmd_valid_n, cmd_len_n       burst command offered by client n
//   cmd_ready_n                  client n is idle and can take a command
//   src_data_n, src_pop_n        client n's current beat / beat-taken pulse
//   req_n, gnt_n                 registered request to, and grant from, the arbiter
//   bus_valid, bus_ready         shared downstream handshake
//   bus_data, bus_src, bus_last  beat payload, owning client, final-beat flag
//   err_dual_gnt                 sticky flag: both grants were seen in one cycle
// ---------------------------------------------------------------------------
module burst_req_ctrl #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              cmd_valid_0,
   input  logic [LEN_W-1:0]  cmd_len_0,
   output logic              cmd_ready_0,
   input  logic [DATA_W-1:0] src_data_0,
   output logic              src_pop_0,
   output logic              req_0,
   input  logic              gnt_0,

   input  logic              cmd_valid_1,
   input  logic [LEN_W-1:0]  cmd_len_1,
   output logic              cmd_ready_1,
   input  logic [DATA_W-1:0] src_data_1,
   output logic              src_pop_1,
   output logic              req_1,
   input  logic              gnt_1,

   output logic              bus_valid,
   input  logic              bus_ready,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_src,
   output logic              bus_last,

   output logic              err_dual_gnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state_0, next_0;
   state_t           state_1, next_1;
   logic [LEN_W-1:0] count_0, count_next_0;
   logic [LEN_W-1:0] count_1, count_next_1;

   logic dual_gnt;
   logic own_0, own_1;
   logic fire_0, fire_1;

   // Bus ownership. A grant is put to use in the very cycle it arrives, so a
   // client still sitting in REQ already drives its first beat; that is what
   // lets the first beat appear in the same cycle the grant rises. RELEASE
   // never owns the bus, so a grant left over from the previous burst can
   // never carry data. When both grants are high client 0 wins and client 1
   // simply stalls for that cycle.
   always_comb begin
      dual_gnt = gnt_0 && gnt_1;
      own_0    = ((state_0 == REQ) || (state_0 == XFER)) && gnt_0;
      own_1    = ((state_1 == REQ) || (state_1 == XFER)) && gnt_1 && !gnt_0;
      fire_0   = own_0 && bus_ready;
      fire_1   = own_1 && bus_ready;
   end

   // Shared bus mux. Everything is forced to zero whenever nobody owns the
   // bus so downstream never sees stale data or a stale owner id.
   always_comb begin
      bus_valid = 1'b0;
      bus_data  = '0;
      bus_src   = 1'b0;
      bus_last  = 1'b0;
      if (own_0) begin
         bus_valid = 1'b1;
         bus_data  = src_data_0;
         bus_last  = (count_0 == LEN_ONE);
      end else if (own_1) begin
         bus_valid = 1'b1;
         bus_data  = src_data_1;
         bus_src   = 1'b1;
         bus_last  = (count_1 == LEN_ONE);
      end
   end

   // Handshake outputs that follow straight from state: a client is ready
   // for a command only when idle, and it pops its source exactly when its
   // beat is accepted downstream.
   always_comb begin
      cmd_ready_0 = (state_0 == IDLE);
      cmd_ready_1 = (state_1 == IDLE);
      src_pop_0   = fire_0;
      src_pop_1   = fire_1;
   end

   // Client 0 next-state and remaining-beat counter. A zero length is loaded
   // as one beat. A dropped grant in REQ/XFER just stalls: no beat moves and
   // the counter holds, while the request stays up.
   always_comb begin
      next_0       = state_0;
      count_next_0 = count_0;
      case (state_0)
         IDLE: begin
            if (cmd_valid_0) begin
               next_0       = REQ;
               count_next_0 = (cmd_len_0 == '0) ? LEN_ONE : cmd_len_0;
            end
         end
         REQ, XFER: begin
            if (fire_0) begin
               count_next_0 = count_0 - LEN_ONE;
               next_0       = (count_0 == LEN_ONE) ? RELEASE : XFER;
            end else if (gnt_0) begin
               next_0 = XFER;
            end
         end
         RELEASE: begin
            if (!gnt_0) begin
               next_0 = IDLE;
            end
         end
         default: next_0 = IDLE;
      endcase
   end

   // Client 1 next-state and remaining-beat counter, same rules as client 0.
   // Its grant only leaves REQ on gnt_1 itself; whether a beat moves is
   // decided by ownership, which already accounts for a clashing gnt_0.
   always_comb begin
      next_1       = state_1;
      count_next_1 = count_1;
      case (state_1)
         IDLE: begin
            if (cmd_valid_1) begin
               next_1       = REQ;
               count_next_1 = (cmd_len_1 == '0) ? LEN_ONE : cmd_len_1;
            end
         end
         REQ, XFER: begin
            if (fire_1) begin
               count_next_1 = count_1 - LEN_ONE;
               next_1       = (count_1 == LEN_ONE) ? RELEASE : XFER;
            end else if (gnt_1) begin
               next_1 = XFER;
            end
         end
         RELEASE: begin
            if (!gnt_1) begin
               next_1 = IDLE;
            end
         end
         default: next_1 = IDLE;
      endcase
   end

   // State, counters and the registered requests. Each request is driven from
   // the next state so it rises the cycle after a command is taken and falls
   // the cycle after the last beat moves. The dual-grant flag only ever sets;
   // reset is the only way to clear it. A reset mid-burst drops everything
   // back to idle, so no further pops can follow.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_0      <= IDLE;
         state_1      <= IDLE;
         count_0      <= '0;
         count_1      <= '0;
         req_0        <= 1'b0;
         req_1        <= 1'b0;
         err_dual_gnt <= 1'b0;
      end else begin
         state_0      <= next_0;
         state_1      <= next_1;
         count_0      <= count_next_0;
         count_1      <= count_next_1;
         req_0        <= (next_0 == REQ) || (next_0 == XFER);
         req_1        <= (next_1 == REQ) || (next_1 == XFER);
         err_dual_gnt <= err_dual_gnt || dual_gnt;
      end
   end

endmodule
